// File: rtl/lcd_bus_sequencer.sv
// HD44780-style write-only byte bus engine: FIFO-buffered command/data bytes driven onto the
// LCD pins with setup, enable-pulse, hold and execution-delay timing. Define LCD_AUTO_INIT_EN
// to have the sequencer issue the 4-byte init sequence itself after power-up.
module lcd_bus_sequencer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int T_SETUP_CYC = 3,
    parameter int T_EN_CYC    = 13,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_ON
);

`ifdef LCD_AUTO_INIT_EN
    localparam bit AUTO_INIT = 1'b1;
`else
    localparam bit AUTO_INIT = 1'b0;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int MAX_DLY = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_CMD_CYC)),
                                  max2(T_CLR_CYC, T_PWRUP_CYC));
    localparam int CNT_W   = $clog2(MAX_DLY + 1);

    // A state lasting N cycles loads N-1 on entry and leaves when the count reaches 0.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'((T_SETUP_CYC > 0) ? T_SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'((T_EN_CYC    > 0) ? T_EN_CYC    - 1 : 0);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'((T_HOLD_CYC  > 0) ? T_HOLD_CYC  - 1 : 0);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'((T_CMD_CYC   > 0) ? T_CMD_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'((T_CLR_CYC   > 0) ? T_CLR_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'((T_PWRUP_CYC > 0) ? T_PWRUP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_INIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [2:0]         init_cnt, init_cnt_next;

    logic [8:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;
    logic [8:0]         fifo_head;

    logic               lcd_on_q, lcd_en_q, lcd_rs_q;
    logic [7:0]         lcd_data_q;
    logic               init_load, en_next, long_wait;
    logic [7:0]         init_byte;

    assign fifo_full  = (fifo_count == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    // lcd_on_q is low only in the reset-held PWRUP state, which blocks uploads until the first edge.
    assign in_ready   = !fifo_full && lcd_on_q;
    assign fifo_push  = in_valid && in_ready;
    assign long_wait  = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02) ||
                                      (lcd_data_q == 8'h03));

    always_comb begin
        case (init_cnt[1:0])
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_PWRUP;
            cnt      <= '0;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        init_cnt_next = init_cnt;
        case (state)
            ST_PWRUP: begin
                if (!lcd_on_q) begin
                    cnt_next = LD_PWRUP;
                end else if (cnt == '0) begin
                    state_next = AUTO_INIT ? ST_INIT : ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            ST_INIT: begin
                state_next    = ST_SETUP;
                cnt_next      = LD_SETUP;
                init_cnt_next = init_cnt + 3'd1;
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_PULSE;
                    cnt_next   = LD_EN;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_next = ST_WAIT;
                    cnt_next   = long_wait ? LD_CLR : LD_CMD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = (AUTO_INIT && (init_cnt != 3'd4)) ? ST_INIT : ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_PWRUP;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        fifo_pop  = (state == ST_IDLE) && !fifo_empty;
        init_load = (state == ST_INIT);
        en_next   = (state_next == ST_PULSE);
        busy      = (state != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {in_rs, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Pins are registered so EN is glitch-free; RS/DATA only move when a byte is launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcd_on_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            lcd_on_q <= 1'b1;
            lcd_en_q <= en_next;
            if (fifo_pop) begin
                lcd_rs_q   <= fifo_head[8];
                lcd_data_q <= fifo_head[7:0];
            end else if (init_load) begin
                lcd_rs_q   <= 1'b0;
                lcd_data_q <= init_byte;
            end
        end
    end

    assign LCD_DATA = lcd_data_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_EN   = lcd_en_q;
    assign LCD_ON   = lcd_on_q;
    assign LCD_RW   = 1'b0;

endmodule
